// File: rtl/pll_recfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_recfg_seq
//  Description : Sequencer that steps a PLL through a table of ROM-stored
//                frequency settings. It drives an ALTPLL_RECONFIG-style
//                controller: write-from-ROM, wait ready, reconfig strobe,
//                then wait for busy to drop (with a timeout that resets the
//                controller). Supports manual step up/down and an
//                auto-sweep mode that advances while the memory tester is
//                reporting both passes and failures.
//
//  Ports
//    clock_50_i          in   sole clock, rising edge
//    RESET               in   synchronous, active-high reset
//    step_up             in   pulse: pos-1 (higher frequency)
//    step_down           in   pulse: pos+1 (lower frequency)
//    auto_tgl            in   pulse: toggle auto-sweep mode
//    pass_nz / fail_nz   in   tester pass / fail counts are non-zero
//    rcfg_busy           in   reconfig controller busy
//    rcfg_write_from_rom out  1-cycle strobe
//    rcfg_reconfig       out  1-cycle strobe
//    rcfg_reset          out  1-cycle strobe (after timeout)
//    pos[3:0]            out  selected frequency index
//    auto                out  auto-sweep active
//    recfg_active        out  high whenever the sequencer is not idle
//    done                out  1-cycle pulse on completed reconfiguration
//    timeout_err         out  sticky timeout flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module pll_recfg_seq #(
    parameter int NUM_POS  = 11,
    parameter int INIT_POS = 7,
    parameter int TIMEOUT  = 1000,
    parameter int HOLDOFF  = 16
) (
    input  logic       clock_50_i,
    input  logic       RESET,
    input  logic       step_up,
    input  logic       step_down,
    input  logic       auto_tgl,
    input  logic       pass_nz,
    input  logic       fail_nz,
    input  logic       rcfg_busy,
    output logic       rcfg_write_from_rom,
    output logic       rcfg_reconfig,
    output logic       rcfg_reset,
    output logic [3:0] pos,
    output logic       auto,
    output logic       recfg_active,
    output logic       done,
    output logic       timeout_err
);

    // +2 keeps the width at least 1 bit even for a zero parameter
    localparam int                   c_timer_w  = $clog2(TIMEOUT + 2);
    localparam int                   c_hold_w   = $clog2(HOLDOFF + 2);
    localparam logic [3:0]           c_last_pos = 4'(NUM_POS - 1);
    localparam logic [3:0]           c_init_pos = 4'(INIT_POS);
    localparam logic [c_timer_w-1:0] c_timeout  = c_timer_w'(TIMEOUT);
    localparam logic [c_hold_w-1:0]  c_holdoff  = c_hold_w'(HOLDOFF);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        GAP       = 3'd2,
        WAIT_RDY  = 3'd3,
        TRIG      = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_UP   = 2'd1,
        REQ_DOWN = 2'd2,
        REQ_TGL  = 2'd3
    } req_t;

    state_t               r_state;
    state_t               w_state_nxt;
    req_t                 r_pend;
    req_t                 w_new_req;
    req_t                 w_req;
    logic [c_timer_w-1:0] r_timer;
    logic [c_hold_w-1:0]  r_holdoff;
    logic [3:0]           r_pos;
    logic                 r_auto;
    logic                 r_wfr;
    logic                 r_reconfig;
    logic                 r_rcfg_rst;
    logic                 r_active;
    logic                 r_done;
    logic                 r_tmo_err;
    logic                 w_accept;
    logic [3:0]           w_pos_nxt;
    logic                 w_auto_nxt;
    logic                 w_done;
    logic                 w_tmo;

    // Simultaneous pulses collapse to one request: auto_tgl > step_down > step_up
    always_comb begin
        w_new_req = REQ_NONE;
        if (auto_tgl) begin
            w_new_req = REQ_TGL;
        end else if (step_down) begin
            w_new_req = REQ_DOWN;
        end else if (step_up) begin
            w_new_req = REQ_UP;
        end
    end

    // Request evaluation; only acted on while IDLE. A fresh pulse takes
    // precedence over the pending slot, and any request (even a discarded
    // one) blocks auto-advance for that cycle.
    always_comb begin
        w_req      = (w_new_req != REQ_NONE) ? w_new_req : r_pend;
        w_accept   = 1'b0;
        w_pos_nxt  = r_pos;
        w_auto_nxt = r_auto;
        case (w_req)
            REQ_UP: begin
                if (r_pos != 4'd0) begin
                    w_accept   = 1'b1;
                    w_pos_nxt  = r_pos - 4'd1;
                    w_auto_nxt = 1'b0;
                end
            end
            REQ_DOWN: begin
                if (r_pos < c_last_pos) begin
                    w_accept   = 1'b1;
                    w_pos_nxt  = r_pos + 4'd1;
                    w_auto_nxt = 1'b0;
                end
            end
            REQ_TGL: begin
                w_accept = 1'b1;
                if (r_auto) begin
                    w_auto_nxt = 1'b0;
                end else begin
                    w_auto_nxt = 1'b1;
                    w_pos_nxt  = 4'd0;
                end
            end
            default: begin
                if (r_auto && pass_nz && fail_nz && (r_holdoff == '0) &&
                    (r_pos < c_last_pos)) begin
                    w_accept  = 1'b1;
                    w_pos_nxt = r_pos + 4'd1;
                end
            end
        endcase
    end

    // FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE:      if (w_accept) w_state_nxt = LOAD;
            LOAD:      w_state_nxt = GAP;
            GAP:       w_state_nxt = WAIT_RDY;
            WAIT_RDY:  if (!rcfg_busy) w_state_nxt = TRIG;
            TRIG:      w_state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                // busy dropping wins over a simultaneous timer expiry
                if (!rcfg_busy) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else if (r_timer <= c_timer_w'(1)) begin
                    w_state_nxt = IDLE;
                    w_tmo       = 1'b1;
                end
            end
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_50_i) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes are registered from the next state so each output is a clean
    // flop that is high exactly for the cycle spent in its state.
    always_ff @(posedge clock_50_i) begin
        if (RESET) begin
            r_pend     <= REQ_NONE;
            r_timer    <= '0;
            r_holdoff  <= '0;
            r_pos      <= c_init_pos;
            r_auto     <= 1'b0;
            r_wfr      <= 1'b0;
            r_reconfig <= 1'b0;
            r_rcfg_rst <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_accept) begin
                r_pos  <= w_pos_nxt;
                r_auto <= w_auto_nxt;
            end

            // The pending slot is consumed (accepted or discarded) in IDLE
            if (r_state == IDLE) begin
                r_pend <= REQ_NONE;
            end else if (w_new_req != REQ_NONE) begin
                r_pend <= w_new_req;
            end

            if (r_state == TRIG) begin
                r_timer <= c_timeout;
            end else if ((r_state == WAIT_DONE) && (r_timer != '0)) begin
                r_timer <= r_timer - c_timer_w'(1);
            end

            if (w_done || w_tmo) begin
                r_holdoff <= c_holdoff;
            end else if ((r_state == IDLE) && (r_holdoff != '0)) begin
                r_holdoff <= r_holdoff - c_hold_w'(1);
            end

            r_wfr      <= (w_state_nxt == LOAD);
            r_reconfig <= (w_state_nxt == TRIG);
            r_rcfg_rst <= w_tmo;
            r_done     <= w_done;
            r_active   <= (w_state_nxt != IDLE);
            r_tmo_err  <= r_tmo_err | w_tmo;
        end
    end

    assign rcfg_write_from_rom = r_wfr;
    assign rcfg_reconfig       = r_reconfig;
    assign rcfg_reset          = r_rcfg_rst;
    assign pos                 = r_pos;
    assign auto                = r_auto;
    assign recfg_active        = r_active;
    assign done                = r_done;
    assign timeout_err         = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_pll_recfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_recfg_seq
//  Description : Self-checking bench for pll_recfg_seq. Expected pos values
//                are pushed to a queue when a request is driven and popped
//                when the DUT strobes rcfg_write_from_rom. A small model of
//                the reconfig controller drives rcfg_busy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_recfg_seq;

    localparam int NUM_POS  = 11;
    localparam int INIT_POS = 7;
    localparam int TIMEOUT  = 1000;
    localparam int HOLDOFF  = 16;
    localparam int WR_BUSY  = 3;
    localparam int RC_BUSY  = 5;

    localparam int S_DONE   = 0;
    localparam int S_RECFG  = 1;
    localparam int S_LOAD   = 2;
    localparam int S_RRST   = 3;

    logic       clock_50_i = 1'b0;
    logic       RESET      = 1'b1;
    logic       step_up    = 1'b0;
    logic       step_down  = 1'b0;
    logic       auto_tgl   = 1'b0;
    logic       pass_nz    = 1'b0;
    logic       fail_nz    = 1'b0;
    logic       rcfg_busy  = 1'b0;
    logic       rcfg_write_from_rom;
    logic       rcfg_reconfig;
    logic       rcfg_reset;
    logic [3:0] pos;
    logic       auto;
    logic       recfg_active;
    logic       done;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int sb_exp;
    int m_pos  = INIT_POS;
    int m_auto = 0;
    bit rc_stuck = 1'b0;
    int busy_cnt = 0;

    pll_recfg_seq #(
        .NUM_POS  (NUM_POS),
        .INIT_POS (INIT_POS),
        .TIMEOUT  (TIMEOUT),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clock_50_i          (clock_50_i),
        .RESET               (RESET),
        .step_up             (step_up),
        .step_down           (step_down),
        .auto_tgl            (auto_tgl),
        .pass_nz             (pass_nz),
        .fail_nz             (fail_nz),
        .rcfg_busy           (rcfg_busy),
        .rcfg_write_from_rom (rcfg_write_from_rom),
        .rcfg_reconfig       (rcfg_reconfig),
        .rcfg_reset          (rcfg_reset),
        .pos                 (pos),
        .auto                (auto),
        .recfg_active        (recfg_active),
        .done                (done),
        .timeout_err         (timeout_err)
    );

    always #10 clock_50_i = ~clock_50_i;

    // Reconfig controller model: busy for WR_BUSY cycles after a ROM write,
    // RC_BUSY cycles after a reconfig strobe (or effectively forever when
    // rc_stuck is set; clearing rc_stuck releases it).
    always @(negedge clock_50_i) begin
        if (rcfg_write_from_rom === 1'b1) begin
            busy_cnt = WR_BUSY;
        end else if (rcfg_reconfig === 1'b1) begin
            busy_cnt = rc_stuck ? 2000 : RC_BUSY;
        end else if (busy_cnt > 0) begin
            busy_cnt = (!rc_stuck && busy_cnt > 100) ? 0 : busy_cnt - 1;
        end
        rcfg_busy = (busy_cnt != 0);
    end

    // Scoreboard: every ROM write must match the next expected pos
    always @(negedge clock_50_i) begin
        if (rcfg_write_from_rom === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_load: unexpected ROM write at pos=%0d, none expected", pos);
            end else begin
                sb_exp = exp_q.pop_front();
                if (pos !== 4'(sb_exp)) begin
                    n_bad++;
                    $display("FAIL sb_load_pos: got pos=%0d, expected %0d", pos, sb_exp);
                end
            end
        end
    end

    // Reference behaviour of one request; returns 1 when a reconfig starts
    function automatic bit model_req(input bit up, input bit dn, input bit tg);
        if (tg) begin
            if (m_auto != 0) begin
                m_auto = 0;
            end else begin
                m_auto = 1;
                m_pos  = 0;
            end
            return 1'b1;
        end
        if (dn) begin
            if (m_pos < NUM_POS - 1) begin
                m_pos++;
                m_auto = 0;
                return 1'b1;
            end
            return 1'b0;
        end
        if (up) begin
            if (m_pos > 0) begin
                m_pos--;
                m_auto = 0;
                return 1'b1;
            end
            return 1'b0;
        end
        return 1'b0;
    endfunction

    // Called just after a negedge; returns at the following negedge
    task automatic pulse(input bit up, input bit dn, input bit tg);
        step_up   = up;
        step_down = dn;
        auto_tgl  = tg;
        @(negedge clock_50_i);
        step_up   = 1'b0;
        step_down = 1'b0;
        auto_tgl  = 1'b0;
    endtask

    task automatic request(input bit up, input bit dn, input bit tg);
        if (model_req(up, dn, tg)) exp_q.push_back(m_pos);
        pulse(up, dn, tg);
    endtask

    task automatic wait_strobe(input int sel, input int limit, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clock_50_i);
            cyc++;
            case (sel)
                S_DONE:  seen = (done === 1'b1);
                S_RECFG: seen = (rcfg_reconfig === 1'b1);
                S_LOAD:  seen = (rcfg_write_from_rom === 1'b1);
                default: seen = (rcfg_reset === 1'b1);
            endcase
        end
    endtask

    task automatic watch_quiet(input int n, output int act);
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock_50_i);
            if (recfg_active !== 1'b0 || rcfg_write_from_rom !== 1'b0 || rcfg_reconfig !== 1'b0 ||
                rcfg_reset !== 1'b0 || done !== 1'b0) act++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge clock_50_i);
        n_cmp++; if (pos !== 4'd7) begin n_bad++; $display("FAIL reset_pos: got %0d, expected 7", pos); end
        n_cmp++; if (auto !== 1'b0) begin n_bad++; $display("FAIL reset_auto: got %b, expected 0", auto); end
        n_cmp++; if (recfg_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b, expected 0", recfg_active); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo_err: got %b, expected 0", timeout_err); end
        n_cmp++;
        if ({rcfg_write_from_rom, rcfg_reconfig, rcfg_reset, done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b, expected 0000",
                     {rcfg_write_from_rom, rcfg_reconfig, rcfg_reset, done});
        end
        RESET  = 1'b0;
        m_pos  = INIT_POS;
        m_auto = 0;
        repeat (2) @(negedge clock_50_i);
        n_cmp++; if (recfg_active !== 1'b0 || pos !== 4'd7) begin
            n_bad++; $display("FAIL reset_release: got active=%b pos=%0d, expected 0/7", recfg_active, pos);
        end
    endtask

    task automatic test_step_up();
        bit seen; int cyc;
        request(1'b1, 1'b0, 1'b0);
        n_cmp++; if (rcfg_write_from_rom !== 1'b1) begin n_bad++; $display("FAIL up_load_strobe: got %b, expected 1", rcfg_write_from_rom); end
        n_cmp++; if (pos !== 4'd6) begin n_bad++; $display("FAIL up_pos: got %0d, expected 6", pos); end
        n_cmp++; if (recfg_active !== 1'b1) begin n_bad++; $display("FAIL up_active: got %b, expected 1", recfg_active); end
        wait_strobe(S_RECFG, 20, seen, cyc);
        n_cmp++; if (!seen || cyc != 4) begin n_bad++; $display("FAIL up_reconfig_lat: got seen=%b cyc=%0d, expected 1/4", seen, cyc); end
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || cyc != 6) begin n_bad++; $display("FAIL up_done_lat: got seen=%b cyc=%0d, expected 1/6", seen, cyc); end
        @(negedge clock_50_i);
        n_cmp++; if (done !== 1'b0 || recfg_active !== 1'b0) begin
            n_bad++; $display("FAIL up_after_done: got done=%b active=%b, expected 0/0", done, recfg_active);
        end
    endtask

    task automatic test_step_down();
        bit seen; int cyc;
        request(1'b0, 1'b1, 1'b0);
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd7 || auto !== 1'b0) begin
            n_bad++; $display("FAIL down_result: got seen=%b pos=%0d auto=%b, expected 1/7/0", seen, pos, auto);
        end
    endtask

    task automatic test_priority();
        bit seen; int cyc; int act;
        request(1'b0, 1'b1, 1'b1);
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd0 || auto !== 1'b1) begin
            n_bad++; $display("FAIL prio_result: got seen=%b pos=%0d auto=%b, expected 1/0/1", seen, pos, auto);
        end
        watch_quiet(30, act);
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL prio_single: got %0d active cycles, expected 0", act); end
    endtask

    task automatic test_auto_off();
        bit seen; int cyc;
        request(1'b0, 1'b0, 1'b1);
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd0 || auto !== 1'b0) begin
            n_bad++; $display("FAIL auto_off: got seen=%b pos=%0d auto=%b, expected 1/0/0", seen, pos, auto);
        end
    endtask

    task automatic test_up_at_zero();
        int act;
        request(1'b1, 1'b0, 1'b0);
        watch_quiet(20, act);
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL up_at_zero_quiet: got %0d active cycles, expected 0", act); end
        n_cmp++; if (pos !== 4'd0 || auto !== 1'b0) begin
            n_bad++; $display("FAIL up_at_zero_state: got pos=%0d auto=%b, expected 0/0", pos, auto);
        end
    endtask

    task automatic test_auto_sweep();
        bit seen; int cyc; int act;
        pass_nz = 1'b1;
        fail_nz = 1'b1;
        request(1'b0, 1'b0, 1'b1);
        for (int p = 1; p < NUM_POS; p++) exp_q.push_back(p);
        m_pos = NUM_POS - 1;
        for (int k = 0; k < NUM_POS; k++) begin
            wait_strobe(S_DONE, 100, seen, cyc);
            n_cmp++; if (!seen) begin n_bad++; $display("FAIL sweep_done: step %0d got no done, expected done", k); end
            if (k < NUM_POS - 1) begin
                wait_strobe(S_LOAD, 100, seen, cyc);
                n_cmp++; if (!seen || cyc - 1 < HOLDOFF) begin
                    n_bad++; $display("FAIL sweep_holdoff: step %0d got seen=%b idle=%0d, expected >=%0d", k, seen, cyc - 1, HOLDOFF);
                end
            end
        end
        watch_quiet(60, act);
        n_cmp++; if (act != 0 || pos !== 4'd10 || auto !== 1'b1) begin
            n_bad++; $display("FAIL sweep_top: got act=%0d pos=%0d auto=%b, expected 0/10/1", act, pos, auto);
        end
        pass_nz = 1'b0;
        fail_nz = 1'b0;
    endtask

    task automatic test_down_at_top();
        bit seen; int cyc; int act;
        request(1'b0, 1'b1, 1'b0);
        watch_quiet(20, act);
        n_cmp++; if (act != 0 || pos !== 4'd10 || auto !== 1'b1) begin
            n_bad++; $display("FAIL down_at_top: got act=%0d pos=%0d auto=%b, expected 0/10/1", act, pos, auto);
        end
        request(1'b1, 1'b0, 1'b0);
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd9 || auto !== 1'b0) begin
            n_bad++; $display("FAIL up_from_top: got seen=%b pos=%0d auto=%b, expected 1/9/0", seen, pos, auto);
        end
    endtask

    task automatic test_pending();
        bit seen; int cyc;
        request(1'b1, 1'b0, 1'b0);
        @(negedge clock_50_i);
        @(negedge clock_50_i);
        request(1'b0, 1'b1, 1'b0);
        wait_strobe(S_DONE, 50, seen, cyc);
        wait_strobe(S_LOAD, 20, seen, cyc);
        n_cmp++; if (!seen || cyc != 1) begin n_bad++; $display("FAIL pend_service: got seen=%b cyc=%0d, expected 1/1", seen, cyc); end
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd9) begin n_bad++; $display("FAIL pend_pos: got seen=%b pos=%0d, expected 1/9", seen, pos); end
    endtask

    task automatic test_overwrite();
        bit seen; int cyc;
        request(1'b1, 1'b0, 1'b0);
        @(negedge clock_50_i);
        pulse(1'b0, 1'b1, 1'b0);
        request(1'b1, 1'b0, 1'b0);
        wait_strobe(S_DONE, 50, seen, cyc);
        wait_strobe(S_LOAD, 20, seen, cyc);
        n_cmp++; if (!seen || cyc != 1) begin n_bad++; $display("FAIL ovw_service: got seen=%b cyc=%0d, expected 1/1", seen, cyc); end
        wait_strobe(S_DONE, 50, seen, cyc);
        n_cmp++; if (!seen || pos !== 4'd7) begin n_bad++; $display("FAIL ovw_pos: got seen=%b pos=%0d, expected 1/7", seen, pos); end
    endtask

    task automatic test_timeout();
        bit seen; int cyc;
        rc_stuck = 1'b1;
        request(1'b0, 1'b1, 1'b0);
        wait_strobe(S_RECFG, 20, seen, cyc);
        wait_strobe(S_RRST, 1100, seen, cyc);
        n_cmp++; if (!seen || cyc != TIMEOUT + 1) begin
            n_bad++; $display("FAIL tmo_latency: got seen=%b cyc=%0d, expected 1/%0d", seen, cyc, TIMEOUT + 1);
        end
        n_cmp++; if (timeout_err !== 1'b1 || recfg_active !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL tmo_state: got err=%b active=%b done=%b, expected 1/0/0", timeout_err, recfg_active, done);
        end
        @(negedge clock_50_i);
        rc_stuck = 1'b0;
        n_cmp++; if (rcfg_reset !== 1'b0 || timeout_err !== 1'b1 || pos !== 4'd8) begin
            n_bad++; $display("FAIL tmo_after: got rst=%b err=%b pos=%0d, expected 0/1/8", rcfg_reset, timeout_err, pos);
        end
        request(1'b1, 1'b0, 1'b0);
        wait_strobe(S_DONE, 100, seen, cyc);
        n_cmp++; if (!seen || timeout_err !== 1'b1 || pos !== 4'd7) begin
            n_bad++; $display("FAIL tmo_sticky: got seen=%b err=%b pos=%0d, expected 1/1/7", seen, timeout_err, pos);
        end
    endtask

    task automatic test_reset_mid();
        bit seen; int cyc; int act;
        request(1'b1, 1'b0, 1'b0);
        wait_strobe(S_RECFG, 20, seen, cyc);
        @(negedge clock_50_i);
        @(negedge clock_50_i);
        RESET = 1'b1;
        @(negedge clock_50_i);
        n_cmp++; if (pos !== 4'd7 || recfg_active !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_state: got pos=%0d active=%b done=%b err=%b, expected 7/0/0/0", pos, recfg_active, done, timeout_err);
        end
        @(negedge clock_50_i);
        RESET  = 1'b0;
        m_pos  = INIT_POS;
        m_auto = 0;
        watch_quiet(20, act);
        n_cmp++; if (act != 0 || pos !== 4'd7) begin
            n_bad++; $display("FAIL rstmid_quiet: got act=%0d pos=%0d, expected 0/7", act, pos);
        end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_step_down();
        test_priority();
        test_auto_off();
        test_up_at_zero();
        test_auto_sweep();
        test_down_at_top();
        test_pending();
        test_overwrite();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d outstanding loads, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
